// File: rtl/warp_pkg.sv
// ---------------------------------------------------------------------------
// warp_pkg
// Shared definitions for the lane_array SIMD block: ALU opcodes, control FSM
// states, instruction field positions, per-op latencies and sizing limits.
// No ports (package).
// ---------------------------------------------------------------------------
package warp_pkg;

    localparam int MAX_LANES = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int LAT_W     = 3;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int DST_MSB    = 22;
    localparam int DST_LSB    = 18;
    localparam int SRC1_MSB   = 17;
    localparam int SRC1_LSB   = 13;
    localparam int SRC2_MSB   = 12;
    localparam int SRC2_LSB   = 8;

    // Per-op latency in busy cycles
    localparam logic [LAT_W-1:0] LAT_ADD = 3'd1;
    localparam logic [LAT_W-1:0] LAT_MUL = 3'd3;
    localparam logic [LAT_W-1:0] LAT_MAX = 3'd1;
    localparam logic [LAT_W-1:0] LAT_FMA = 3'd4;
    localparam logic [LAT_W-1:0] LAT_NOP = 3'd1;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_MUL = 4'h1,
        OP_MAX = 4'h2,
        OP_FMA = 4'h3
    } alu_opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } array_state_e;

    // Unknown opcodes behave as single-cycle NOPs
    function automatic logic [LAT_W-1:0] op_latency(input logic [3:0] op);
        case (op)
            OP_ADD:  op_latency = LAT_ADD;
            OP_MUL:  op_latency = LAT_MUL;
            OP_MAX:  op_latency = LAT_MAX;
            OP_FMA:  op_latency = LAT_FMA;
            default: op_latency = LAT_NOP;
        endcase
    endfunction

endpackage

// File: rtl/warp_lane.sv
// ---------------------------------------------------------------------------
// warp_lane
// One SIMD processing lane: private 32x32-bit register file plus an ALU whose
// result is committed after an opcode-dependent number of cycles.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           broadcast issue pulse (one cycle, from the array FSM)
//   enable          this lane's bit of the issue mask, valid with start
//   opcode          instruction opcode
//   dst/src1/src2   register indices
//   done            high during this lane's final busy cycle
// Parameter LANE_ID sets the reset contents: register r = LANE_ID*32 + r.
// ---------------------------------------------------------------------------
module warp_lane
    import warp_pkg::*;
#(
    parameter int LANE_ID = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 enable,
    input  logic [3:0]           opcode,
    input  logic [REG_IDX_W-1:0] dst,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    output logic                 done
);

    logic [31:0]          regs [NUM_REGS];
    logic                 active;
    logic [LAT_W-1:0]     cnt;
    logic [3:0]           op_q;
    logic [REG_IDX_W-1:0] dst_q;
    logic [31:0]          opa;
    logic [31:0]          opb;
    logic [31:0]          opc;
    logic [31:0]          result;
    logic                 writes;

    // Result is formed from operands captured at issue; the latency counter
    // only decides when it is committed.
    always_comb begin
        result = '0;
        writes = 1'b0;
        case (op_q)
            OP_ADD: begin
                result = opa + opb;
                writes = 1'b1;
            end
            OP_MUL: begin
                result = opa * opb;
                writes = 1'b1;
            end
            OP_MAX: begin
                result = ($signed(opa) > $signed(opb)) ? opa : opb;
                writes = 1'b1;
            end
            OP_FMA: begin
                result = opa * opb + opc;
                writes = 1'b1;
            end
            default: begin
                result = '0;
                writes = 1'b0;
            end
        endcase
    end

    assign done = active && (cnt == 3'd1);

    // Operands (including FMA's old dst) are read at the issue edge so later
    // writes cannot affect an in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= 32'(LANE_ID * NUM_REGS + r);
            end
            active <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            dst_q  <= '0;
            opa    <= '0;
            opb    <= '0;
            opc    <= '0;
        end else if (start && enable) begin
            active <= 1'b1;
            cnt    <= op_latency(opcode);
            op_q   <= opcode;
            dst_q  <= dst;
            opa    <= regs[src1];
            opb    <= regs[src2];
            opc    <= regs[dst];
        end else if (active) begin
            if (cnt == 3'd1) begin
                active <= 1'b0;
                if (writes) begin
                    regs[dst_q] <= result;
                end
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

endmodule

// File: rtl/lane_array.sv
// ---------------------------------------------------------------------------
// lane_array
// SIMD execution array: NUM_LANES warp_lane instances share one broadcast
// instruction; a per-issue mask selects participating lanes.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   execute         issue strobe, honoured only while ready
//   instruction     [31:28] opcode, [22:18] dst, [17:13] src1, [12:8] src2
//   lane_enable     per-lane execute mask, sampled with execute
//   ready           array idle and able to accept an issue
// ---------------------------------------------------------------------------
module lane_array
    import warp_pkg::*;
#(
    parameter int NUM_LANES = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 execute,
    input  logic [31:0]          instruction,
    input  logic [NUM_LANES-1:0] lane_enable,
    output logic                 ready
);

    array_state_e         state;
    array_state_e         next_state;
    logic [NUM_LANES-1:0] mask_q;
    logic [NUM_LANES-1:0] done;
    logic                 accept;
    logic                 all_done;
    logic                 unused_fields;

    assign unused_fields = ^{instruction[27:23], instruction[7:0]};

    assign ready  = (state == IDLE);
    // An all-zero mask is swallowed without leaving IDLE
    assign accept = ready && execute && (|lane_enable);
    // Masked-off lanes never raise done, so they count as finished
    assign all_done = &(done | ~mask_q);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)   next_state = BUSY;
            BUSY:    if (all_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                mask_q <= lane_enable;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        warp_lane #(
            .LANE_ID(l)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (accept),
            .enable (lane_enable[l]),
            .opcode (instruction[OPCODE_MSB:OPCODE_LSB]),
            .dst    (instruction[DST_MSB:DST_LSB]),
            .src1   (instruction[SRC1_MSB:SRC1_LSB]),
            .src2   (instruction[SRC2_MSB:SRC2_LSB]),
            .done   (done[l])
        );
    end

endmodule

// File: tb/tb_lane_array.sv
// ---------------------------------------------------------------------------
// tb_lane_array
// Self-checking bench for lane_array with four lanes. A register-file model
// tracks expected lane contents; busy length is measured on ready.
// ---------------------------------------------------------------------------
module tb_lane_array;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          execute;
    logic [31:0]   instruction;
    logic [NL-1:0] lane_enable;
    logic          ready;

    int errors = 0;
    int checks = 0;
    int low_cycles;

    logic [31:0] model [NL][32];

    lane_array #(
        .NUM_LANES(NL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .execute     (execute),
        .instruction (instruction),
        .lane_enable (lane_enable),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dutReg(input int l, input int r);
        case (l)
            0:       return dut.g_lane[0].u_lane.regs[r];
            1:       return dut.g_lane[1].u_lane.regs[r];
            2:       return dut.g_lane[2].u_lane.regs[r];
            3:       return dut.g_lane[3].u_lane.regs[r];
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] mkInstr(input logic [3:0] op, input logic [4:0] d,
                                            input logic [4:0] s1, input logic [4:0] s2);
        return {op, 5'b0, d, s1, s2, 8'h00};
    endfunction

    function automatic int expLatency(input logic [3:0] op);
        case (op)
            4'h1:    return 3;
            4'h3:    return 4;
            default: return 1;
        endcase
    endfunction

    task automatic modelReset();
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < 32; r++)
                model[l][r] = 32'(l * 32 + r);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAllRegs(input string tag);
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < 32; r++)
                checkOutput($sformatf("%s lane%0d r%0d", tag, l, r), dutReg(l, r), model[l][r]);
    endtask

    // Called at a negedge with ready=1; returns at the first negedge where
    // ready is 1 again, so consecutive calls issue with no bubble.
    task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic [NL-1:0] mask);
        logic [3:0]  op;
        logic [31:0] a, b, c;
        logic [63:0] prod;
        logic [31:0] nxt [NL];
        logic        wr;
        int          exp_low;

        op = instr[31:28];
        exp_low = (mask == '0) ? 0 : expLatency(op);
        wr = (op <= 4'h3);
        for (int l = 0; l < NL; l++) begin
            a = model[l][instr[17:13]];
            b = model[l][instr[12:8]];
            c = model[l][instr[22:18]];
            prod = 64'(a) * 64'(b);
            case (op)
                4'h0:    nxt[l] = a + b;
                4'h1:    nxt[l] = prod[31:0];
                4'h2:    nxt[l] = ($signed(a) > $signed(b)) ? a : b;
                4'h3:    nxt[l] = prod[31:0] + c;
                default: nxt[l] = c;
            endcase
        end

        instruction = instr;
        lane_enable = mask;
        execute     = 1'b1;
        @(posedge clk);
        #1;
        low_cycles = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (ready) break;
            low_cycles++;
            // Junk on the inputs while busy must be ignored
            execute     = 1'($urandom);
            instruction = $urandom;
            lane_enable = NL'($urandom);
        end
        execute = 1'b0;
        checkOutput({tag, " busy cycles"}, 32'(low_cycles), 32'(exp_low));

        for (int l = 0; l < NL; l++)
            if (mask[l] && wr)
                model[l][instr[22:18]] = nxt[l];
        checkAllRegs(tag);
    endtask

    initial begin
        logic [3:0]    rop;
        logic [31:0]   rin;
        logic [NL-1:0] rmask;

        rst_n       = 1'b0;
        execute     = 1'b0;
        instruction = '0;
        lane_enable = '0;
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ready", 32'(ready), 32'd1);
        checkOutput("reset lane2 r7", dutReg(2, 7), 32'd71);
        checkAllRegs("reset");

        applyStimulus("add all", mkInstr(4'h0, 5'd1, 5'd2, 5'd3), 4'b1111);
        checkOutput("add lane0 r1", dutReg(0, 1), 32'd5);
        checkOutput("add lane3 r1", dutReg(3, 1), 32'd197);

        applyStimulus("mul lane0", mkInstr(4'h1, 5'd4, 5'd5, 5'd6), 4'b0001);
        checkOutput("mul lane0 r4", dutReg(0, 4), 32'd30);
        checkOutput("mul lane1 r4", dutReg(1, 4), 32'd36);
        checkOutput("mul lane2 r4", dutReg(2, 4), 32'd68);
        checkOutput("mul lane3 r4", dutReg(3, 4), 32'd100);

        applyStimulus("max 0101", mkInstr(4'h2, 5'd8, 5'd9, 5'd10), 4'b0101);
        applyStimulus("add 1010", mkInstr(4'h0, 5'd9, 5'd10, 5'd11), 4'b1010);
        applyStimulus("zero mask", mkInstr(4'h0, 5'd1, 5'd30, 5'd31), 4'b0000);
        applyStimulus("nop", mkInstr(4'h9, 5'd2, 5'd3, 5'd4), 4'b1111);

        applyStimulus("fma all", mkInstr(4'h3, 5'd20, 5'd21, 5'd22), 4'b1111);
        checkOutput("fma lane0 r20", dutReg(0, 20), 32'd482);

        // Reset in the middle of an FMA aborts it without writeback
        instruction = mkInstr(4'h3, 5'd20, 5'd21, 5'd22);
        lane_enable = 4'b1111;
        execute     = 1'b1;
        @(posedge clk);
        execute = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset ready", 32'(ready), 32'd1);
        checkOutput("midreset lane0 r20", dutReg(0, 20), 32'd20);
        checkOutput("midreset lane0 r1", dutReg(0, 1), 32'd1);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post reset ready", 32'(ready), 32'd1);
        checkAllRegs("post reset");

        for (int i = 0; i < 40; i++) begin
            rop   = ((i % 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            rin   = $urandom;
            rin[31:28] = rop;
            rmask = NL'($urandom);
            applyStimulus($sformatf("rand%0d", i), rin, rmask);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
